// File: rtl/cpu_types_pkg.sv
// Shared CPU types: 32-bit word, fetch FSM states and next-PC select codes.
package cpu_types_pkg;

   typedef logic [31:0] word_t;

   localparam word_t PC_STEP = 32'd4;

   typedef enum logic [1:0] {RUN, REDIR_WAIT, HALTED} fetch_state_t;

   typedef enum logic [1:0] {PcHold, PcInc, PcTgt, PcSaved} pc_sel_t;

   // Instruction addresses are word aligned; low two bits are dropped.
   function automatic word_t align_word(input word_t addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: icache request/response, hazard/redirect inputs, IF/ID outputs.
interface fetch_stage_if;

   cpu_types_pkg::word_t iload;
   cpu_types_pkg::word_t iaddr;
   cpu_types_pkg::word_t brnch_addr;
   cpu_types_pkg::word_t jmp_addr;
   cpu_types_pkg::word_t ifinstr;
   cpu_types_pkg::word_t ifJALjump_addr;
   logic                 ihit;
   logic                 iREN;
   logic                 stall;
   logic                 halt;
   logic                 brnch_take;
   logic                 jmp_take;
   logic                 ifW;
   logic                 ifFlush;

   modport master (
      input  ihit, iload, stall, halt, brnch_take, brnch_addr, jmp_take, jmp_addr,
      output iREN, iaddr, ifW, ifFlush, ifinstr, ifJALjump_addr
   );

   modport slave (
      output ihit, iload, stall, halt, brnch_take, brnch_addr, jmp_take, jmp_addr,
      input  iREN, iaddr, ifW, ifFlush, ifinstr, ifJALjump_addr
   );

endinterface

// File: rtl/fetch_stage_pc_unit.sv
// PC register with next-PC mux: hold, pc+4, redirect target or saved target.
module pc_unit
   import cpu_types_pkg::*;
#(
   parameter word_t PC_INIT = 32'h0000_0000
) (
   input  logic    CLK,
   input  logic    nRST,
   input  pc_sel_t sel,
   input  word_t   target,
   input  word_t   saved_tgt,
   output word_t   pc
);

   word_t pc_d;

   always_comb begin
      pc_d = pc;
      unique case (sel)
         PcHold:  pc_d = pc;
         PcInc:   pc_d = pc + PC_STEP;
         PcTgt:   pc_d = target;
         PcSaved: pc_d = saved_tgt;
         default: pc_d = pc;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (nRST) begin
         pc <= PC_INIT;
      end else begin
         pc <= pc_d;
      end
   end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the icache and the IF/ID register controls.
module fetch_stage
   import cpu_types_pkg::*;
#(
   parameter word_t PC_INIT = 32'h0000_0000
) (
   input logic           CLK,
   input logic           nRST,
   fetch_stage_if.master bus
);

   fetch_state_t state_q, state_d;
   word_t        saved_q, saved_d;
   word_t        pc;
   word_t        target;
   word_t        brnch_tgt;
   pc_sel_t      pc_sel;
   logic         redirect;

   pc_unit #(
      .PC_INIT (PC_INIT)
   ) u_pc_unit (
      .CLK       (CLK),
      .nRST      (nRST),
      .sel       (pc_sel),
      .target    (target),
      .saved_tgt (saved_q),
      .pc        (pc)
   );

   always_comb begin
      // The MEM-stage branch is older than the ID-stage jump, so it wins.
      redirect  = bus.brnch_take | bus.jmp_take;
      target    = align_word(bus.brnch_take ? bus.brnch_addr : bus.jmp_addr);
      brnch_tgt = align_word(bus.brnch_addr);

      state_d            = state_q;
      saved_d            = saved_q;
      pc_sel             = PcHold;
      bus.iREN           = 1'b0;
      bus.iaddr          = pc;
      bus.ifW            = 1'b0;
      bus.ifFlush        = 1'b0;
      bus.ifinstr        = bus.iload;
      bus.ifJALjump_addr = pc + PC_STEP;

      if (nRST) begin
         bus.iaddr          = '0;
         bus.ifinstr        = '0;
         bus.ifJALjump_addr = '0;
      end else begin
         unique case (state_q)
            RUN: begin
               bus.iREN = 1'b1;
               if (bus.halt) begin
                  state_d = HALTED;
               end else if (redirect && bus.ihit) begin
                  pc_sel      = PcTgt;
                  bus.ifFlush = 1'b1;
               end else if (redirect) begin
                  // iaddr must stay stable until the outstanding miss returns.
                  saved_d     = target;
                  state_d     = REDIR_WAIT;
                  bus.ifFlush = 1'b1;
               end else if (bus.stall) begin
                  pc_sel = PcHold;
               end else if (bus.ihit) begin
                  bus.ifW = 1'b1;
                  pc_sel  = PcInc;
               end
            end
            REDIR_WAIT: begin
               bus.iREN = 1'b1;
               // A late jump comes from a flushed instruction; only branches matter.
               if (bus.brnch_take) begin
                  saved_d = brnch_tgt;
               end
               if (bus.ihit) begin
                  pc_sel  = bus.brnch_take ? PcTgt : PcSaved;
                  state_d = RUN;
               end
               if (bus.halt) begin
                  state_d = HALTED;
               end
            end
            HALTED: begin
               state_d = HALTED;
            end
            default: begin
               state_d = RUN;
            end
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (nRST) begin
         state_q <= RUN;
         saved_q <= '0;
      end else begin
         state_q <= state_d;
         saved_q <= saved_d;
      end
   end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: sequencing, misses, redirects, stall, halt, reset, wrap.
module tb_fetch_stage;

   logic CLK;
   logic nRST;
   int   total;
   int   bad;

   fetch_stage_if bus ();

   fetch_stage #(
      .PC_INIT (32'h0000_0000)
   ) dut (
      .CLK  (CLK),
      .nRST (nRST),
      .bus  (bus.master)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic ck_out(input string tag, input logic [31:0] addr, input logic ren,
                         input logic w, input logic flush);
      chk({tag, "_iaddr"}, bus.iaddr, addr);
      chk({tag, "_iREN"}, {31'd0, bus.iREN}, {31'd0, ren});
      chk({tag, "_ifW"}, {31'd0, bus.ifW}, {31'd0, w});
      chk({tag, "_ifFlush"}, {31'd0, bus.ifFlush}, {31'd0, flush});
   endtask

   task automatic idle();
      bus.ihit       = 1'b0;
      bus.iload      = 32'h0;
      bus.stall      = 1'b0;
      bus.halt       = 1'b0;
      bus.brnch_take = 1'b0;
      bus.brnch_addr = 32'h0;
      bus.jmp_take   = 1'b0;
      bus.jmp_addr   = 32'h0;
   endtask

   // Advance one clock; inputs change 1 time unit after the edge.
   task automatic step();
      @(posedge CLK);
      #1;
      idle();
   endtask

   initial begin
      total = 0;
      bad   = 0;
      nRST  = 1'b1;
      idle();
      bus.ihit  = 1'b1;
      bus.iload = 32'hdead_beef;
      #2;
      ck_out("rst", 32'h0, 1'b0, 1'b0, 1'b0);
      chk("rst_instr", bus.ifinstr, 32'h0);
      chk("rst_jal", bus.ifJALjump_addr, 32'h0);
      step();
      nRST = 1'b0;

      for (int i = 0; i < 4; i++) begin
         bus.ihit  = 1'b1;
         bus.iload = 32'h1000 + i;
         #1;
         ck_out("seq", 32'(4 * i), 1'b1, 1'b1, 1'b0);
         chk("seq_jal", bus.ifJALjump_addr, 32'(4 * i + 4));
         chk("seq_instr", bus.ifinstr, 32'h1000 + i);
         step();
      end

      for (int i = 0; i < 3; i++) begin
         #1;
         ck_out("miss", 32'h10, 1'b1, 1'b0, 1'b0);
         step();
      end
      bus.ihit  = 1'b1;
      bus.iload = 32'hcafe_0010;
      #1;
      ck_out("miss_hit", 32'h10, 1'b1, 1'b1, 1'b0);
      chk("miss_instr", bus.ifinstr, 32'hcafe_0010);
      step();

      for (int i = 0; i < 3; i++) begin
         bus.ihit = 1'b1;
         #1;
         ck_out("after_miss", 32'h14 + 32'(4 * i), 1'b1, 1'b1, 1'b0);
         step();
      end

      bus.jmp_take = 1'b1;
      bus.jmp_addr = 32'h80;
      #1;
      ck_out("jmp_miss", 32'h20, 1'b1, 1'b0, 1'b1);
      step();
      bus.jmp_take = 1'b1;
      bus.jmp_addr = 32'h300;
      #1;
      ck_out("wait", 32'h20, 1'b1, 1'b0, 1'b0);
      step();
      bus.ihit = 1'b1;
      #1;
      ck_out("wait_hit", 32'h20, 1'b1, 1'b0, 1'b0);
      step();
      bus.ihit = 1'b1;
      #1;
      ck_out("jmp_tgt", 32'h80, 1'b1, 1'b1, 1'b0);
      step();

      bus.ihit     = 1'b1;
      bus.jmp_take = 1'b1;
      bus.jmp_addr = 32'h40;
      #1;
      ck_out("jmp_hit", 32'h84, 1'b1, 1'b0, 1'b1);
      step();
      bus.ihit       = 1'b1;
      bus.brnch_take = 1'b1;
      bus.brnch_addr = 32'h200;
      bus.jmp_take   = 1'b1;
      bus.jmp_addr   = 32'h300;
      #1;
      ck_out("br_and_jmp", 32'h40, 1'b1, 1'b0, 1'b1);
      step();
      bus.ihit = 1'b1;
      #1;
      ck_out("br_tgt", 32'h200, 1'b1, 1'b1, 1'b0);
      step();

      bus.jmp_take = 1'b1;
      bus.jmp_addr = 32'h80;
      #1;
      ck_out("jmp_miss2", 32'h204, 1'b1, 1'b0, 1'b1);
      step();
      bus.brnch_take = 1'b1;
      bus.brnch_addr = 32'h500;
      #1;
      ck_out("wait_br", 32'h204, 1'b1, 1'b0, 1'b0);
      step();
      bus.ihit = 1'b1;
      #1;
      ck_out("wait_br_hit", 32'h204, 1'b1, 1'b0, 1'b0);
      step();
      bus.ihit = 1'b1;
      #1;
      ck_out("br_override", 32'h500, 1'b1, 1'b1, 1'b0);
      step();

      bus.ihit     = 1'b1;
      bus.jmp_take = 1'b1;
      bus.jmp_addr = 32'h103;
      #1;
      ck_out("unaligned", 32'h504, 1'b1, 1'b0, 1'b1);
      step();
      bus.ihit = 1'b1;
      #1;
      ck_out("aligned_tgt", 32'h100, 1'b1, 1'b1, 1'b0);
      step();

      bus.ihit     = 1'b1;
      bus.jmp_take = 1'b1;
      bus.jmp_addr = 32'h8;
      step();
      for (int i = 0; i < 2; i++) begin
         bus.ihit  = 1'b1;
         bus.stall = 1'b1;
         #1;
         ck_out("stall", 32'h8, 1'b1, 1'b0, 1'b0);
         step();
      end
      bus.ihit = 1'b1;
      bus.halt = 1'b1;
      #1;
      ck_out("halt_run", 32'h8, 1'b1, 1'b0, 1'b0);
      step();
      for (int i = 0; i < 3; i++) begin
         bus.ihit     = 1'b1;
         bus.jmp_take = 1'b1;
         bus.jmp_addr = 32'h40;
         #1;
         chk("halted_iREN", {31'd0, bus.iREN}, 32'd0);
         chk("halted_ifW", {31'd0, bus.ifW}, 32'd0);
         chk("halted_ifFlush", {31'd0, bus.ifFlush}, 32'd0);
         step();
      end

      nRST = 1'b1;
      #1;
      ck_out("rst2", 32'h0, 1'b0, 1'b0, 1'b0);
      step();
      nRST     = 1'b0;
      bus.ihit = 1'b1;
      #1;
      ck_out("rst2_run", 32'h0, 1'b1, 1'b1, 1'b0);
      step();

      bus.jmp_take = 1'b1;
      bus.jmp_addr = 32'h80;
      step();
      nRST = 1'b1;
      step();
      nRST = 1'b0;
      #1;
      ck_out("rst_wait_miss", 32'h0, 1'b1, 1'b0, 1'b0);
      step();
      bus.ihit = 1'b1;
      #1;
      ck_out("rst_wait_hit", 32'h0, 1'b1, 1'b1, 1'b0);
      step();

      bus.ihit     = 1'b1;
      bus.jmp_take = 1'b1;
      bus.jmp_addr = 32'hffff_fffc;
      step();
      bus.ihit = 1'b1;
      #1;
      ck_out("wrap", 32'hffff_fffc, 1'b1, 1'b1, 1'b0);
      chk("wrap_jal", bus.ifJALjump_addr, 32'h0);
      step();
      bus.ihit = 1'b1;
      #1;
      ck_out("wrap_next", 32'h0, 1'b1, 1'b1, 1'b0);
      chk("wrap_next_jal", bus.ifJALjump_addr, 32'h4);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
